acc_calc: RTL and testbench

ACC_CALC -- requirements
Module: acc_calc

---
 rtl/acc_calc_if.sv | 13 +
 rtl/acc_calc.sv | 134 +++++++++++++
 tb/tb_acc_calc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/acc_calc_if.sv
// acc_calc_if -- board-facing I/O bundle for acc_calc.
//   SW[9:0]    : operand in SW[WIDTH-1:0], op select in SW[9:8]
//   HEX0..HEX5 : active-low seven-segment digits, bit 7 is the decimal point
//   LEDR[9:0]  : [7:0] op count, [8] accumulator negative, [9] sticky overflow
// modport master drives the switches; modport slave is the accumulator.
interface acc_calc_if;
    logic [9:0] SW;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    modport master (output SW, input HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
    modport slave  (input SW, output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
endinterface

// File: rtl/acc_calc.sv
// acc_calc -- pushbutton-driven signed accumulator with hex display.
// Ports:
//   MAX10_CLK1_50 : system clock, all state on its rising edge
//   KEY[1]        : asynchronous active-low reset
//   KEY[0]        : active-low execute button (one op per press)
//   io            : acc_calc_if.slave (SW in, HEX0..HEX5 / LEDR out)
// Ops (SW[9:8]): 00 load, 01 add, 10 subtract, 11 clear.
// HEX5..HEX3 show the live operand, HEX2..HEX0 the accumulator, both in
// sign-magnitude hex. LEDR = {sticky overflow, acc negative, op count}.
// Build option: define ACC_SATURATE_EN to clamp overflowing add/subtract
// results instead of wrapping them.
module acc_calc #(
    parameter int WIDTH = 8
) (
    input  logic        MAX10_CLK1_50,
    input  logic [1:0]  KEY,
    acc_calc_if.slave   io
);
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_CLR} op_e;

    logic clk, rst_n;
    assign clk   = MAX10_CLK1_50;
    assign rst_n = KEY[1];

    // ---------------- button synchronizer / edge detect ----------------
    logic       key_s1, key_s2, key_hist, armed, exec;
    logic [1:0] vld_pipe;

    // vld_pipe marks when key_s2 holds a real sample rather than its reset
    // value. armed only sets once the button has really been seen released,
    // so a button held through reset release cannot fire an op.
    // The edge pulse is registered once more, giving the 3-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_hist <= 1'b1;
            vld_pipe <= '0;
            armed    <= 1'b0;
            exec     <= 1'b0;
        end else begin
            key_s1   <= KEY[0];
            key_s2   <= key_s1;
            key_hist <= key_s2;
            vld_pipe <= {vld_pipe[0], 1'b1};
            armed    <= armed | (vld_pipe[1] & key_s2);
            exec     <= armed & key_hist & ~key_s2;
        end
    end

    // ---------------- datapath ----------------
    op_e                     op;
    logic signed [WIDTH-1:0] operand;
    logic signed [WIDTH-1:0] acc, arith;
    logic signed [WIDTH:0]   sum;
    logic                    ovf, sticky;
    logic [7:0]              cnt;

    assign op      = op_e'(io.SW[9:8]);
    assign operand = io.SW[WIDTH-1:0];

    always_comb begin
        sum = '0;
        if (op == OP_SUB)
            sum = {acc[WIDTH-1], acc} - {operand[WIDTH-1], operand};
        else
            sum = {acc[WIDTH-1], acc} + {operand[WIDTH-1], operand};
        // Result outside the WIDTH-bit range when the two top bits disagree.
        ovf = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef ACC_SATURATE_EN
        if (ovf)
            arith = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            arith = sum[WIDTH-1:0];
`else
        arith = sum[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (exec) begin
            cnt <= cnt + 8'd1;
            case (op)
                OP_LOAD: acc <= operand;
                OP_ADD,
                OP_SUB: begin
                    acc    <= arith;
                    sticky <= sticky | ovf;
                end
                OP_CLR: begin
                    acc    <= '0;
                    sticky <= 1'b0;
                end
                default: acc <= acc;
            endcase
        end
    end

    // ---------------- display ----------------
    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
        endcase
    endfunction

    // {sign, high nibble, low nibble}. Magnitude is one bit wider than the
    // value so the most negative number negates without overflow.
    function automatic logic [23:0] show(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext, mag;
        logic [7:0]     m8, s, h, l;
        ext = {v[WIDTH-1], v};
        mag = v[WIDTH-1] ? -ext : ext;
        m8  = 8'(mag);
        s   = v[WIDTH-1] ? 8'hBF : 8'hFF;
        h   = (WIDTH <= 4 || m8[7:4] == 4'h0) ? 8'hFF : glyph(m8[7:4]);
        l   = glyph(m8[3:0]);
        show = {s, h, l};
    endfunction

    assign {io.HEX5, io.HEX4, io.HEX3} = show(io.SW[WIDTH-1:0]);
    assign {io.HEX2, io.HEX1, io.HEX0} = show(acc);
    assign io.LEDR = {sticky, acc[WIDTH-1], cnt};
endmodule

// File: tb/tb_acc_calc.sv
module tb_acc_calc;
    logic       clk = 1'b0;
    logic [1:0] key;
    int         total = 0;
    int         bad   = 0;

    always #10 clk = ~clk;

    acc_calc_if if8 ();
    acc_calc_if if4 ();

    acc_calc #(.WIDTH(8)) dut8 (.MAX10_CLK1_50(clk), .KEY(key), .io(if8));
    acc_calc #(.WIDTH(4)) dut4 (.MAX10_CLK1_50(clk), .KEY(key), .io(if4));

    logic [7:0] glyph_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reference state (8-bit DUT)
    int m_acc, m_cnt;
    bit m_ovf;

    typedef struct {
        logic [1:0] op;
        logic [7:0] val;
        logic [7:0] eacc;
        logic       eovf;
        logic [7:0] ecnt;
    } vec_t;
    vec_t vt [10];

    function automatic int sx8(input logic [7:0] b);
        return b[7] ? int'(b) - 256 : int'(b);
    endfunction

    function automatic logic [23:0] exp_disp(input int v, input int w);
        int mag;
        logic [7:0] s, h, l;
        mag = (v < 0) ? -v : v;
        s = (v < 0) ? 8'hBF : 8'hFF;
        h = (w <= 4 || mag / 16 == 0) ? 8'hFF : glyph_t[mag / 16];
        l = glyph_t[mag % 16];
        return {s, h, l};
    endfunction

    function automatic logic [9:0] exp_ledr();
        return {m_ovf, (m_acc < 0), 8'(m_cnt)};
    endfunction

    task automatic model_step(input logic [1:0] op, input logic [7:0] val);
        int v, r;
        v = sx8(val);
        r = m_acc;
        case (op)
            2'd0: r = v;
            2'd1: r = m_acc + v;
            2'd2: r = m_acc - v;
            default: r = 0;
        endcase
        if (op == 2'd1 || op == 2'd2) begin
            if (r > 127)  begin r = r - 256; m_ovf = 1'b1; end
            if (r < -128) begin r = r + 256; m_ovf = 1'b1; end
        end
        if (op == 2'd3) m_ovf = 1'b0;
        m_acc = r;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        chk({name, "_acc"}, {8'h0, if8.HEX2, if8.HEX1, if8.HEX0}, {8'h0, exp_disp(m_acc, 8)});
        chk({name, "_ledr"}, 32'(if8.LEDR), 32'(exp_ledr()));
        chk({name, "_opnd"}, {8'h0, if8.HEX5, if8.HEX4, if8.HEX3},
            {8'h0, exp_disp(sx8(if8.SW[7:0]), 8)});
    endtask

    // One button press: operand/op held until the button is released.
    task automatic do_op(input logic [9:0] sw8, input logic [9:0] sw4);
        if8.SW = sw8;
        if4.SW = sw4;
        key[0] = 1'b0;
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [23:0] prev;
        int          lat;

        vt[0] = '{2'd0, 8'h05, 8'h05, 1'b0, 8'd1};
        vt[1] = '{2'd1, 8'hFD, 8'h02, 1'b0, 8'd2};
        vt[2] = '{2'd0, 8'h7F, 8'h7F, 1'b0, 8'd3};
        vt[3] = '{2'd1, 8'h01, 8'h80, 1'b1, 8'd4};
        vt[4] = '{2'd0, 8'h80, 8'h80, 1'b1, 8'd5};
        vt[5] = '{2'd2, 8'h01, 8'h7F, 1'b1, 8'd6};
        vt[6] = '{2'd3, 8'h00, 8'h00, 1'b0, 8'd7};
        vt[7] = '{2'd2, 8'h01, 8'hFF, 1'b0, 8'd8};
        vt[8] = '{2'd2, 8'h80, 8'h7F, 1'b0, 8'd9};
        vt[9] = '{2'd1, 8'h7F, 8'hFE, 1'b1, 8'd10};

        key = 2'b01;
        if8.SW = 10'h000;
        if4.SW = 10'h300;
        repeat (3) @(negedge clk);
        chk("reset_ledr", 32'(if8.LEDR), 32'h0);
        chk("reset_hex", {8'h0, if8.HEX2, if8.HEX1, if8.HEX0}, {8'h0, 8'hFF, 8'hFF, 8'hC0});
        key[1] = 1'b1;
        repeat (5) @(negedge clk);
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op({vt[i].op, vt[i].val}, 10'h300);
            model_step(vt[i].op, vt[i].val);
            chk($sformatf("vec%0d_acc", i), {8'h0, if8.HEX2, if8.HEX1, if8.HEX0},
                {8'h0, exp_disp(sx8(vt[i].eacc), 8)});
            chk($sformatf("vec%0d_ledr", i), 32'(if8.LEDR),
                32'({vt[i].eovf, vt[i].eacc[7], vt[i].ecnt}));
        end

        // held button: exactly one op, acc changes 3 edges after first low sample
        prev = {if8.HEX2, if8.HEX1, if8.HEX0};
        if8.SW = {2'd0, 8'h5A};
        key[0] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (lat == 0 && {if8.HEX2, if8.HEX1, if8.HEX0} != prev) lat = k;
        end
        chk("latency", 32'(lat), 32'd4);
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
        model_step(2'd0, 8'h5A);
        check_state("hold");

        // reset mid-press, released with the button still held
        do_op({2'd0, 8'h33}, 10'h300);
        model_step(2'd0, 8'h33);
        check_state("pre_rst");
        key[0] = 1'b0;
        repeat (5) @(negedge clk);
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        check_state("in_rst");
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        check_state("rst_held");
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_state("rst_rise");
        do_op({2'd1, 8'h11}, 10'h300);
        model_step(2'd1, 8'h11);
        check_state("rst_next");

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [7:0] val;
            op  = 2'($urandom_range(0, 3));
            val = 8'($urandom_range(0, 255));
            do_op({op, val}, 10'h300);
            model_step(op, val);
            check_state($sformatf("rnd%0d", i));
        end

        // WIDTH=4 instance: most negative value and wrap on subtract
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
        key[1] = 1'b1;
        repeat (5) @(negedge clk);
        do_op(10'h300, 10'h008);
        chk("w4_load_hex", {8'h0, if4.HEX2, if4.HEX1, if4.HEX0}, {8'h0, 8'hBF, 8'hFF, 8'h80});
        chk("w4_load_ledr", 32'(if4.LEDR), 32'({1'b0, 1'b1, 8'd1}));
        do_op(10'h300, 10'h201);
        chk("w4_sub_hex", {8'h0, if4.HEX2, if4.HEX1, if4.HEX0}, {8'h0, 8'hFF, 8'hFF, 8'hF8});
        chk("w4_sub_ledr", 32'(if4.LEDR), 32'({1'b1, 1'b0, 8'd2}));
        chk("w4_opnd", {8'h0, if4.HEX5, if4.HEX4, if4.HEX3}, {8'h0, 8'hFF, 8'hFF, 8'hF9});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
